// File: rtl/pci_msi_sched.sv
// MSI/INTx interrupt scheduler: latches source pulses as pending bits, arbitrates them
// round-robin and issues one MSI memory write per event. Optional PCI_MSI_PVM_EN adds per-vector masking.
module pci_msi_sched #(
  parameter int NUM_SRC = 4,
  parameter int RR_INIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] pend_clr_i,
  input  logic               msi_enable_i,
  input  logic [2:0]         msi_mme_i,
  input  logic [63:0]        msi_addr_i,
  input  logic [15:0]        msi_data_i,
  input  logic               intx_disable_i,
  output logic               mst_req_o,
  output logic [63:0]        mst_addr_o,
  output logic               mst_dac_o,
  output logic [31:0]        mst_data_o,
  input  logic               mst_gnt_i,
  input  logic               mst_done_i,
  output logic               intx_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy_o
`ifdef PCI_MSI_PVM_EN
  ,
  input  logic [NUM_SRC-1:0] msi_mask_i,
  output logic [NUM_SRC-1:0] msi_pend_bits_o
`endif
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] gnt_clr;
  logic [IDX_W-1:0]   rr_q, sel_q, pick, rr_next;
  logic               found, load, rr_adv;
  logic [63:0]        addr_q;
  logic               dac_q;
  logic [31:0]        data_q;
  logic               intx_q;
  logic [2:0]         vec_lg;
  logic [15:0]        vec_mask, data_low;
  logic               unused_addr_lsbs;

  // Address bits [1:0] are forced to zero on the bus; they are deliberately dropped.
  assign unused_addr_lsbs = ^msi_addr_i[1:0];

`ifdef PCI_MSI_PVM_EN
  assign eligible        = pending_q & ~msi_mask_i;
  assign msi_pend_bits_o = pending_q & msi_mask_i;
`else
  assign eligible        = pending_q;
`endif

  // Round-robin search: first eligible bit at or after rr_q, wrapping modulo NUM_SRC.
  always_comb begin
    int         idx;
    logic [IDX_W-1:0] idx_w;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_w = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = IDX_W'(idx);
      if (!found && eligible[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
  end

  // Vector count V = 2^min(mme,5); the low log2(V) data bits carry the source index mod V.
  assign vec_lg   = (msi_mme_i > 3'd5) ? 3'd5 : msi_mme_i;
  assign vec_mask = ~(16'hFFFF << vec_lg);
  assign data_low = (msi_data_i & ~vec_mask) | (16'(pick) & vec_mask);

  assign rr_next = (sel_q == IDX_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    rr_adv  = 1'b0;
    gnt_clr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (msi_enable_i && found) begin
          state_d = S_REQ;
          load    = 1'b1;
        end
      end
      S_REQ: begin
        if (mst_gnt_i) begin
          gnt_clr[sel_q] = 1'b1;
          rr_adv         = 1'b1;
          state_d        = mst_done_i ? S_IDLE : S_WAIT;
        end else if (!msi_enable_i || !pending_q[sel_q]) begin
          // Disabled or software-cleared before grant: withdraw, the write is never sent.
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mst_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rr_q      <= IDX_W'(RR_INIT);
      sel_q     <= '0;
      addr_q    <= '0;
      dac_q     <= 1'b0;
      data_q    <= '0;
      intx_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      // A pulse OR'd in after the clear makes a coincident irq win over the clear.
      pending_q <= (pending_q & ~(pend_clr_i | gnt_clr)) | irq_i;
      if (load) begin
        sel_q  <= pick;
        addr_q <= {msi_addr_i[63:2], 2'b00};
        dac_q  <= |msi_addr_i[63:32];
        data_q <= {16'h0000, data_low};
      end
      if (rr_adv) rr_q <= rr_next;
      intx_q <= (|pending_q) & ~msi_enable_i & ~intx_disable_i;
    end
  end

  assign mst_req_o  = (state_q == S_REQ);
  assign busy_o     = (state_q != S_IDLE);
  assign mst_addr_o = addr_q;
  assign mst_dac_o  = dac_q;
  assign mst_data_o = data_q;
  assign intx_o     = intx_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_pci_msi_sched.sv
// Self-checking bench for pci_msi_sched: per-cycle vector table plus hand-written sequences
// for request hold, master latency and (with PCI_MSI_PVM_EN) per-vector masking.
module tb_pci_msi_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq_i = '0, pend_clr_i = '0;
  logic        msi_enable_i = 1'b0;
  logic [2:0]  msi_mme_i = '0;
  logic [63:0] msi_addr_i = '0;
  logic [15:0] msi_data_i = '0;
  logic        intx_disable_i = 1'b0;
  logic        mst_gnt_i = 1'b0, mst_done_i = 1'b0;
  logic        mst_req_o, mst_dac_o, intx_o, busy_o;
  logic [63:0] mst_addr_o;
  logic [31:0] mst_data_o;
  logic [3:0]  pending_o;
`ifdef PCI_MSI_PVM_EN
  logic [3:0]  msi_mask_i = '0;
  logic [3:0]  msi_pend_bits_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pci_msi_sched #(.NUM_SRC(4), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .pend_clr_i(pend_clr_i),
    .msi_enable_i(msi_enable_i), .msi_mme_i(msi_mme_i), .msi_addr_i(msi_addr_i),
    .msi_data_i(msi_data_i), .intx_disable_i(intx_disable_i),
    .mst_req_o(mst_req_o), .mst_addr_o(mst_addr_o), .mst_dac_o(mst_dac_o),
    .mst_data_o(mst_data_o), .mst_gnt_i(mst_gnt_i), .mst_done_i(mst_done_i),
    .intx_o(intx_o), .pending_o(pending_o), .busy_o(busy_o)
`ifdef PCI_MSI_PVM_EN
    , .msi_mask_i(msi_mask_i), .msi_pend_bits_o(msi_pend_bits_o)
`endif
  );

  typedef struct {
    int          cfg;
    logic        rst, en, idis, gnt, done;
    logic [3:0]  irq, clr;
    logic        e_req, e_busy, e_intx, e_dac;
    logic [3:0]  e_pend;
    logic [31:0] e_data;
    logic [63:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // cfg 0: single vector, 32-bit address; cfg 1: 4 vectors, DAC address; cfg 2: 4 vectors, 32-bit.
  function automatic vec_t mk(input int cfg, input bit r, input bit [3:0] irq, input bit [3:0] clr,
                              input bit en, input bit idis, input bit gnt, input bit done,
                              input bit e_req, input bit [3:0] e_pend, input bit e_busy,
                              input bit e_intx, input bit [31:0] e_data);
    vec_t v;
    v.cfg = cfg; v.rst = r; v.irq = irq; v.clr = clr; v.en = en; v.idis = idis;
    v.gnt = gnt; v.done = done; v.e_req = e_req; v.e_pend = e_pend; v.e_busy = e_busy;
    v.e_intx = e_intx; v.e_data = e_data;
    if (cfg == 1) begin
      v.e_addr = 64'h0000_0001_FEE0_0004; v.e_dac = 1'b1;
    end else begin
      v.e_addr = 64'h0000_0000_FEE0_0000; v.e_dac = 1'b0;
    end
    return v;
  endfunction

  task automatic set_cfg(input int cfg);
    case (cfg)
      1:       begin msi_mme_i = 3'd2; msi_addr_i = 64'h0000_0001_FEE0_0007; msi_data_i = 16'h4020; end
      2:       begin msi_mme_i = 3'd2; msi_addr_i = 64'h0000_0000_FEE0_0000; msi_data_i = 16'h4020; end
      default: begin msi_mme_i = 3'd0; msi_addr_i = 64'h0000_0000_FEE0_0000; msi_data_i = 16'h4021; end
    endcase
  endtask

  task automatic idle_inputs();
    rst = 1'b0; irq_i = '0; pend_clr_i = '0; msi_enable_i = 1'b1; intx_disable_i = 1'b0;
    mst_gnt_i = 1'b0; mst_done_i = 1'b0; set_cfg(0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    //                cfg rst irq      clr      en idis gnt done  req pend    busy intx data
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0, 0, 0,   0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0100, 4'b0000, 1, 0, 0, 0,   0, 4'b0100, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b0100, 1, 0, 32'h0000_4021));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 1, 0,   0, 4'b0000, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 1,   0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'b1000, 4'b0000, 1, 0, 0, 0,   0, 4'b1000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b1000, 1, 0, 32'h0000_4023));
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 1, 1,   0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b1111, 4'b0000, 1, 0, 0, 0,   0, 4'b1111, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b1111, 1, 0, 32'h0000_4020));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 0,   0, 4'b1110, 1, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 1,   0, 4'b1110, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b1110, 1, 0, 32'h0000_4021));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 1,   0, 4'b1100, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b1100, 1, 0, 32'h0000_4022));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 1,   0, 4'b1000, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b1000, 1, 0, 32'h0000_4023));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 1,   0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0011, 4'b0000, 1, 0, 0, 0,   0, 4'b0011, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b0011, 1, 0, 32'h0000_4020));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 1,   0, 4'b0010, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b0010, 1, 0, 32'h0000_4021));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 1,   0, 4'b0000, 0, 0, 32'h0));
    // Abort on enable drop in REQ, reissue, and re-pulse during WAIT.
    vecs.push_back(mk(2, 0, 4'b0001, 4'b0000, 1, 0, 0, 0,   0, 4'b0001, 0, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b0001, 1, 0, 32'h0000_4020));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 4'b0001, 0, 1, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b0001, 1, 0, 32'h0000_4020));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 0,   0, 4'b0000, 1, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0001, 4'b0000, 1, 0, 0, 0,   0, 4'b0001, 1, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 0, 0, 0, 1,   0, 4'b0001, 0, 1, 32'h0));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b0001, 1, 0, 32'h0000_4020));
    vecs.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 1, 1,   0, 4'b0000, 0, 0, 32'h0));
    // INTx fallback, interrupt disable, software clear, clear vs pulse collision.
    vecs.push_back(mk(0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0,   0, 4'b0010, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 4'b0010, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0,   0, 4'b0010, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 4'b0010, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0010, 0, 0, 0, 0,   0, 4'b0000, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0010, 4'b0010, 0, 0, 0, 0,   0, 4'b0010, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 4'b0010, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0010, 0, 0, 0, 0,   0, 4'b0000, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 32'h0));
    // MSI mode: bit cleared by software before grant is withdrawn.
    vecs.push_back(mk(0, 0, 4'b1000, 4'b0000, 1, 0, 0, 0,   0, 4'b1000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b1000, 1, 0, 0, 0,   1, 4'b0000, 1, 0, 32'h0000_4021));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   0, 4'b0000, 0, 0, 32'h0));
    // Reset while requesting, with a coincident pulse that must be lost.
    vecs.push_back(mk(0, 0, 4'b0001, 4'b0000, 1, 0, 0, 0,   0, 4'b0001, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   1, 4'b0001, 1, 0, 32'h0000_4021));
    vecs.push_back(mk(0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0,   0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,   0, 4'b0000, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      set_cfg(vecs[i].cfg);
      rst = vecs[i].rst; irq_i = vecs[i].irq; pend_clr_i = vecs[i].clr;
      msi_enable_i = vecs[i].en; intx_disable_i = vecs[i].idis;
      mst_gnt_i = vecs[i].gnt; mst_done_i = vecs[i].done;
      tick();
      check($sformatf("v%0d req", i),  64'(mst_req_o), 64'(vecs[i].e_req));
      check($sformatf("v%0d pend", i), 64'(pending_o), 64'(vecs[i].e_pend));
      check($sformatf("v%0d busy", i), 64'(busy_o),    64'(vecs[i].e_busy));
      check($sformatf("v%0d intx", i), 64'(intx_o),    64'(vecs[i].e_intx));
      if (vecs[i].e_req) begin
        check($sformatf("v%0d addr", i), mst_addr_o,      vecs[i].e_addr);
        check($sformatf("v%0d dac", i),  64'(mst_dac_o),  64'(vecs[i].e_dac));
        check($sformatf("v%0d data", i), 64'(mst_data_o), 64'(vecs[i].e_data));
      end
    end

    // Slow master: request must hold with stable address/data until the grant arrives.
    @(negedge clk); idle_inputs(); irq_i = 4'b0100;
    tick();
    @(negedge clk); irq_i = '0;
    ok = 1'b0;
    for (int k = 0; k < 5 && !ok; k++) begin
      tick();
      ok = mst_req_o;
    end
    check("hold req seen", 64'(ok), 64'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold req c%0d", k),  64'(mst_req_o), 64'(1));
      check($sformatf("hold addr c%0d", k), mst_addr_o, 64'h0000_0000_FEE0_0000);
      check($sformatf("hold data c%0d", k), 64'(mst_data_o), 64'h4021);
    end
    @(negedge clk); mst_gnt_i = 1'b1;
    tick();
    check("hold gnt req", 64'(mst_req_o), 64'(0));
    check("hold gnt pend", 64'(pending_o), 64'(0));
    @(negedge clk); mst_gnt_i = 1'b0;
    tick(); tick();
    check("wait busy", 64'(busy_o), 64'(1));
    @(negedge clk); mst_done_i = 1'b1;
    tick();
    check("done busy", 64'(busy_o), 64'(0));
    @(negedge clk); mst_done_i = 1'b0;

`ifdef PCI_MSI_PVM_EN
    // Masked source stays pending and unserved; unmasking releases it; masking in REQ does not abort.
    @(negedge clk); msi_mask_i = 4'b0001; irq_i = 4'b0001;
    tick();
    check("pvm pend bits", 64'(msi_pend_bits_o), 64'(4'b0001));
    @(negedge clk); irq_i = '0;
    tick(); tick();
    check("pvm masked req", 64'(mst_req_o), 64'(0));
    check("pvm masked pend", 64'(pending_o), 64'(4'b0001));
    @(negedge clk); msi_mask_i = '0;
    tick();
    check("pvm unmask req", 64'(mst_req_o), 64'(1));
    check("pvm unmask data", 64'(mst_data_o), 64'h4021);
    @(negedge clk); msi_mask_i = 4'b0001;
    tick();
    check("pvm mask in req", 64'(mst_req_o), 64'(1));
    @(negedge clk); mst_gnt_i = 1'b1; mst_done_i = 1'b1;
    tick();
    check("pvm served pend", 64'(pending_o), 64'(0));
    check("pvm served busy", 64'(busy_o), 64'(0));
    @(negedge clk); mst_gnt_i = 1'b0; mst_done_i = 1'b0; msi_mask_i = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
